spi_master_tx: RTL and testbench

Transmit-side SPI master paired with the 12-bit SPI slave receiver. It accepts a parallel word from local logic and generates `sync_clock` from the system clock. It frames the word with active-low `CS` and shifts it out on `MOSI` so the slave samples every bit on a `sync_clock` rising edge. It sits between the host-side register logic and the off-block SPI link.

---
 rtl/spi_master_tx.sv | 126 ++++++++++++
 tb/tb_spi_master_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// spi_master_tx: transmit-side SPI master.
// Generates a free-running sync_clock from clk and shifts one DATA_WIDTH word per frame
// on MOSI, framed by active-low CS. Every CS/MOSI change happens on a sync_clock falling
// edge, so data is stable around each rising edge where the slave samples.
// Optional build macro: SPI_MASTER_TX_MSB_FIRST_EN selects MSB-first bit order
// (default is LSB first). Frame timing is the same in both builds.
module spi_master_tx #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_data,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  ready,
  output logic                  sync_clock,
  output logic                  CS,
  output logic                  MOSI,
  output logic                  done
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StStart, StSend, StStop} state_e;

  state_e                state_q;
  logic [DivW-1:0]       div_cnt_q;
  logic [BitW-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic                  pending_q;

  logic                  div_tick;
  logic                  fall_tick;
  logic                  accept;
  logic                  next_bit;
  logic [DATA_WIDTH-1:0] shreg_shifted;

  assign div_tick  = (div_cnt_q == DivLast);
  // sync_clock is about to go 1->0 on this edge
  assign fall_tick = div_tick & sync_clock;
  assign accept    = ready & new_data;

`ifdef SPI_MASTER_TX_MSB_FIRST_EN
  assign next_bit      = shreg_q[DATA_WIDTH-1];
  assign shreg_shifted = shreg_q << 1;
`else
  assign next_bit      = shreg_q[0];
  assign shreg_shifted = shreg_q >> 1;
`endif

  // Clock divider: toggle sync_clock every CLK_DIV clk cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      sync_clock <= 1'b0;
    end else if (div_tick) begin
      div_cnt_q  <= '0;
      sync_clock <= ~sync_clock;
    end else begin
      div_cnt_q  <= div_cnt_q + DivW'(1);
    end
  end

  // Request capture and frame FSM with registered CS/MOSI/done/ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      pending_q <= 1'b0;
      ready     <= 1'b1;
      CS        <= 1'b1;
      MOSI      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // ready is only high in idle with nothing pending, so this never collides with shifting
      if (accept) begin
        shreg_q   <= din;
        pending_q <= 1'b1;
        ready     <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (fall_tick && pending_q) begin
            state_q   <= StStart;
            pending_q <= 1'b0;
            CS        <= 1'b0;
            MOSI      <= 1'b0;
          end
        end
        StStart: begin
          if (fall_tick) begin
            state_q   <= StSend;
            bit_cnt_q <= '0;
            MOSI      <= next_bit;
            shreg_q   <= shreg_shifted;
          end
        end
        StSend: begin
          if (fall_tick) begin
            if (bit_cnt_q == BitLast) begin
              state_q <= StStop;
              CS      <= 1'b1;
              MOSI    <= 1'b0;
              done    <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
              MOSI      <= next_bit;
              shreg_q   <= shreg_shifted;
            end
          end
        end
        StStop: begin
          state_q <= StIdle;
          ready   <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Testbench for spi_master_tx. A cycle-level reference model derived from the timing rules
// (edge count since reset, fall ticks at multiples of 2*CLK_DIV) predicts every output on
// every cycle; a receiver rebuilds each word from MOSI at sync_clock rising edges.
module tb_spi_master_tx;

  localparam int unsigned DW    = 12;
  localparam int unsigned CD    = 4;
  localparam int unsigned PER   = 2 * CD;
  localparam int unsigned FRAME = (DW + 1) * PER;

  logic          clk = 1'b0;
  logic          rst;
  logic          new_data;
  logic [DW-1:0] din;
  logic          ready;
  logic          sync_clock;
  logic          cs;
  logic          mosi;
  logic          done;

  spi_master_tx #(
    .DATA_WIDTH(DW),
    .CLK_DIV   (CD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .new_data  (new_data),
    .din       (din),
    .ready     (ready),
    .sync_clock(sync_clock),
    .CS        (cs),
    .MOSI      (mosi),
    .done      (done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model state
  int unsigned   n        = 0;   // clk edges since reset released
  bit            m_active = 1'b0;
  bit            m_ready  = 1'b1;
  int unsigned   m_start  = 0;   // edge on which CS falls
  logic [DW-1:0] m_word   = '0;
  bit            accepted = 1'b0;
  int            exp_dones = 0;
  int            obs_dones = 0;

  // Receiver state
  logic          prev_sc  = 1'b0;
  int            rx_cnt   = 0;
  logic [DW-1:0] rx_word  = '0;
  int            cs_gap   = 0;
  bit            seen_frame = 1'b0;
  logic          prev_cs  = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Word bit position carried by the i-th data bit of a frame.
  function automatic int unsigned bit_pos(input int unsigned i);
`ifdef SPI_MASTER_TX_MSB_FIRST_EN
    return DW - 1 - i;
`else
    return i;
`endif
  endfunction

  task automatic step();
    logic        e_sc, e_cs, e_mosi, e_done;
    int unsigned k;
    @(posedge clk);
    accepted = 1'b0;
    if (rst) begin
      n        = 0;
      m_active = 1'b0;
      m_ready  = 1'b1;
    end else begin
      n++;
      if (new_data && m_ready) begin
        m_word   = din;
        m_start  = (n / PER + 1) * PER;
        m_active = 1'b1;
        m_ready  = 1'b0;
        accepted = 1'b1;
      end else if (m_active && n == m_start + FRAME + 1) begin
        m_active = 1'b0;
        m_ready  = 1'b1;
      end
    end
    @(negedge clk);
    e_sc   = ((n / CD) % 2) == 1;
    e_cs   = 1'b1;
    e_mosi = 1'b0;
    e_done = 1'b0;
    if (m_active && n >= m_start && n < m_start + FRAME) begin
      e_cs = 1'b0;
      k    = (n - m_start) / PER;
      if (k > 0) e_mosi = m_word[bit_pos(k - 1)];
    end else if (m_active && n == m_start + FRAME) begin
      e_done = 1'b1;
    end
    check("sync_clock", 32'(sync_clock), 32'(e_sc));
    check("cs", 32'(cs), 32'(e_cs));
    check("mosi", 32'(mosi), 32'(e_mosi));
    check("done", 32'(done), 32'(e_done));
    check("ready", 32'(ready), 32'(m_ready));
    if (e_done) exp_dones++;
    if (done === 1'b1) begin
      obs_dones++;
      check("rx_bits", 32'(rx_cnt), 32'(DW + 1));
      check("rx_word", 32'(rx_word), 32'(m_word));
    end
    // Receiver: sample MOSI on sync_clock rising edges while selected
    if (sync_clock === 1'b1 && prev_sc === 1'b0 && cs === 1'b0) begin
      if (rx_cnt >= 1 && rx_cnt <= DW) rx_word[bit_pos(rx_cnt - 1)] = mosi;
      else if (rx_cnt == 0) check("start_mosi", 32'(mosi), 32'(0));
      rx_cnt++;
    end
    if (cs === 1'b0 && prev_cs === 1'b1) begin
      if (seen_frame) check("cs_gap_ok", 32'(cs_gap >= int'(PER)), 32'(1));
      seen_frame = 1'b1;
      cs_gap     = 0;
    end
    if (cs === 1'b1) begin
      rx_cnt = 0;
      cs_gap++;
    end
    prev_sc = sync_clock;
    prev_cs = cs;
  endtask

  task automatic run(input int unsigned cycles);
    repeat (cycles) begin
      din = DW'($urandom);
      step();
    end
  endtask

  task automatic send(input logic [DW-1:0] w);
    new_data = 1'b1;
    din      = w;
    step();
    new_data = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned c = 0;
    while (!m_ready && c < budget) begin
      din = DW'($urandom);
      step();
      c++;
    end
    if (!m_ready) check("idle_timeout", 32'(c), 32'(budget + 1));
  endtask

  initial begin
    int unsigned c;
    int          got;
    rst      = 1'b1;
    new_data = 1'b0;
    din      = '0;
    repeat (3) step();
    // Request during reset is discarded
    new_data = 1'b1;
    din      = 12'h123;
    step();
    new_data = 1'b0;
    rst      = 1'b0;
    run(100);

    // Single frame, with a mid-frame request that must be ignored
    send(12'hA5C);
    run(40);
    send(12'hFFF);
    wait_idle(4 * FRAME);
    run(3);

    // Back-to-back: second word accepted as soon as ready returns
    new_data = 1'b1;
    din      = 12'h001;
    got      = 0;
    c        = 0;
    while (got < 2 && c < 4 * FRAME) begin
      step();
      c++;
      if (accepted) begin
        got++;
        din = 12'h800;
      end
    end
    new_data = 1'b0;
    if (got < 2) check("b2b_accepts", 32'(got), 32'(2));
    wait_idle(4 * FRAME);
    run(5);

    // Reset while bit 5 is on the wire
    send(12'h3C3);
    c = 0;
    while (!(m_active && n >= m_start + 6 * PER + 1) && c < 4 * FRAME) begin
      step();
      c++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_cs", 32'(cs), 32'(1));
    check("rst_ready", 32'(ready), 32'(1));
    run(10);
    send(12'h3C3);
    wait_idle(4 * FRAME);

    // Random words with random noise requests and gaps
    for (int i = 0; i < 6; i++) begin
      send(DW'($urandom));
      run($urandom_range(5, 60));
      if ($urandom_range(0, 1) == 1) send(DW'($urandom));
      wait_idle(4 * FRAME);
      run($urandom_range(0, 20));
    end

    check("done_count", 32'(obs_dones), 32'(exp_dones));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
